// File: rtl/test_ram_arbiter.sv
// test_ram_arbiter: round-robin arbiter that shares one registered-read RAM between two single-word requesters
module test_ram_arbiter #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_req0,
    input  logic                  i_req1,
    input  logic                  i_we0,
    input  logic                  i_we1,
    input  logic [ADDR_WIDTH-1:0] i_addr0,
    input  logic [ADDR_WIDTH-1:0] i_addr1,
    input  logic [DATA_WIDTH-1:0] i_wdata0,
    input  logic [DATA_WIDTH-1:0] i_wdata1,
    output logic                  o_gnt0,
    output logic                  o_gnt1,
    output logic                  o_rvalid0,
    output logic                  o_rvalid1,
    output logic [DATA_WIDTH-1:0] o_rdata,
    output logic                  o_busy,
    output logic                  o_ram_we,
    output logic [ADDR_WIDTH-1:0] o_ram_addr,
    output logic [DATA_WIDTH-1:0] o_ram_data_in,
    input  logic [DATA_WIDTH-1:0] i_ram_data_out
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t                r_state;
    logic                  r_last;
    logic                  r_sel;
    logic                  r_rd;
    logic                  r_gnt0;
    logic                  r_gnt1;
    logic                  r_rvalid0;
    logic                  r_rvalid1;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_ram_we;
    logic [ADDR_WIDTH-1:0] r_ram_addr;
    logic [DATA_WIDTH-1:0] r_ram_data_in;

    logic                  w_win;
    logic                  w_we;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [DATA_WIDTH-1:0] w_wdata;

    // Winner: the lone requester, or under contention the port that did not win last time
    always_comb begin
        w_win   = (i_req0 && i_req1) ? ~r_last : i_req1;
        w_we    = w_win ? i_we1 : i_we0;
        w_addr  = w_win ? i_addr1 : i_addr0;
        w_wdata = w_win ? i_wdata1 : i_wdata0;
    end

    // Sequencer: accept in IDLE, drive RAM in ISSUE, collect registered read data on leaving WAIT
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= IDLE;
            r_last        <= 1'b1;
            r_sel         <= 1'b0;
            r_rd          <= 1'b0;
            r_gnt0        <= 1'b0;
            r_gnt1        <= 1'b0;
            r_rvalid0     <= 1'b0;
            r_rvalid1     <= 1'b0;
            r_rdata       <= '0;
            r_ram_we      <= 1'b0;
            r_ram_addr    <= '0;
            r_ram_data_in <= '0;
        end else begin
            r_gnt0    <= 1'b0;
            r_gnt1    <= 1'b0;
            r_rvalid0 <= 1'b0;
            r_rvalid1 <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (i_req0 || i_req1) begin
                        r_state       <= ISSUE;
                        r_last        <= w_win;
                        r_sel         <= w_win;
                        r_rd          <= ~w_we;
                        r_gnt0        <= ~w_win;
                        r_gnt1        <= w_win;
                        r_ram_we      <= w_we;
                        r_ram_addr    <= w_addr;
                        r_ram_data_in <= w_wdata;
                    end
                end
                ISSUE: begin
                    r_state  <= WAIT;
                    r_ram_we <= 1'b0;
                end
                WAIT: begin
                    r_state <= IDLE;
                    if (r_rd) begin
                        r_rdata   <= i_ram_data_out;
                        r_rvalid0 <= ~r_sel;
                        r_rvalid1 <= r_sel;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_gnt0        = r_gnt0;
    assign o_gnt1        = r_gnt1;
    assign o_rvalid0     = r_rvalid0;
    assign o_rvalid1     = r_rvalid1;
    assign o_rdata       = r_rdata;
    assign o_busy        = (r_state != IDLE);
    assign o_ram_we      = r_ram_we;
    assign o_ram_addr    = r_ram_addr;
    assign o_ram_data_in = r_ram_data_in;
endmodule

// File: tb/tb_test_ram_arbiter.sv
// tb_test_ram_arbiter: directed stimulus with grant/read-data scoreboards checked by independent monitors
module tb_test_ram_arbiter;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
    logic [7:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;
    logic       gnt0, gnt1, rvalid0, rvalid1, busy, ram_we;
    logic [7:0] rdata, ram_addr, ram_data_in;
    logic [7:0] ram_data_out = '0;
    logic [7:0] mem [256];

    int errors = 0;
    int checks = 0;
    int gq[$];
    logic [8:0] rq[$];

    always #5 clk = ~clk;

    test_ram_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_req0(req0), .i_req1(req1), .i_we0(we0), .i_we1(we1),
        .i_addr0(addr0), .i_addr1(addr1), .i_wdata0(wdata0), .i_wdata1(wdata1),
        .o_gnt0(gnt0), .o_gnt1(gnt1), .o_rvalid0(rvalid0), .o_rvalid1(rvalid1),
        .o_rdata(rdata), .o_busy(busy), .o_ram_we(ram_we), .o_ram_addr(ram_addr),
        .o_ram_data_in(ram_data_in), .i_ram_data_out(ram_data_out)
    );

    // Registered-read single-port RAM, preloaded with addr ^ 0xA5
    initial for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'hA5;
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_data_in;
        ram_data_out <= mem[ram_addr];
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Grant monitor
    always @(negedge clk) begin
        if (gnt0 || gnt1) begin
            chk("gnt_both", int'(gnt0 & gnt1), 0);
            if (gq.size() == 0) chk("gnt_unexpected", int'(gnt1), -1);
            else chk("gnt_port", int'(gnt1), gq.pop_front());
        end
    end

    // Read-data monitor
    always @(negedge clk) begin
        if (rvalid0 || rvalid1) begin
            logic [8:0] e;
            chk("rv_both", int'(rvalid0 & rvalid1), 0);
            chk("rv_gnt_overlap", int'(gnt0 | gnt1), 0);
            if (rq.size() == 0) chk("rv_unexpected", int'(rvalid1), -1);
            else begin
                e = rq.pop_front();
                chk("rv_port", int'(rvalid1), int'(e[8]));
                chk("rv_data", int'(rdata), int'(e[7:0]));
            end
        end
    end

    task automatic chk_reset_outputs();
        chk("rst_gnt0", int'(gnt0), 0);
        chk("rst_gnt1", int'(gnt1), 0);
        chk("rst_rvalid0", int'(rvalid0), 0);
        chk("rst_rvalid1", int'(rvalid1), 0);
        chk("rst_ram_we", int'(ram_we), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_rdata", int'(rdata), 0);
        chk("rst_ram_addr", int'(ram_addr), 0);
        chk("rst_ram_data_in", int'(ram_data_in), 0);
    endtask

    task automatic drive(input int p, input logic r, input logic w, input logic [7:0] a, input logic [7:0] d);
        if (p == 0) begin req0 = r; we0 = w; addr0 = a; wdata0 = d; end
        else begin req1 = r; we1 = w; addr1 = a; wdata1 = d; end
    endtask

    // Single access from an idle arbiter; returns at the negedge of the following IDLE cycle
    task automatic access(input int p, input logic w, input logic [7:0] a, input logic [7:0] d, input logic [7:0] exp);
        int lat;
        gq.push_back(p);
        if (!w) rq.push_back({p[0], exp});
        @(posedge clk); #1;
        drive(p, 1'b1, w, a, d);
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (p == 0 ? gnt0 : gnt1) begin lat = i; break; end
        end
        chk("gnt_latency", lat, 2);
        if (w) begin
            chk("we_on", int'(ram_we), 1);
            chk("we_addr", int'(ram_addr), int'(a));
            chk("we_data", int'(ram_data_in), int'(d));
        end
        @(posedge clk); #1;
        drive(p, 1'b0, w, a, d);
        @(negedge clk);
        if (w) chk("we_pulse", int'(ram_we), 0);
        @(negedge clk);
        if (!w) chk("rvalid_latency", int'(p == 0 ? rvalid0 : rvalid1), 1);
    endtask

    initial begin
        int n, t, last_t, busy_lo;
        #3;
        chk_reset_outputs();
        @(negedge clk); rst_n = 1'b1;

        // Reset asserted mid-ISSUE of a port-0 write
        gq.push_back(0);
        @(posedge clk); #1;
        drive(0, 1'b1, 1'b1, 8'h05, 8'hAA);
        @(negedge clk);
        @(negedge clk);
        chk("abort_we_before", int'(ram_we), 1);
        #2 rst_n = 1'b0;
        #1 chk_reset_outputs();
        drive(0, 1'b0, 1'b0, 8'h00, 8'h00);
        @(negedge clk);
        chk_reset_outputs();
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        access(0, 1'b0, 8'h05, 8'h00, 8'hA0);

        // Port 0 write then read
        access(0, 1'b1, 8'h10, 8'h3C, 8'h00);
        access(0, 1'b0, 8'h10, 8'h00, 8'h3C);

        // Continuous contention right after reset: port 0 first, then alternate
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        gq.push_back(0); gq.push_back(1); gq.push_back(0); gq.push_back(1);
        rq.push_back({1'b0, 8'h85}); rq.push_back({1'b1, 8'h95});
        rq.push_back({1'b0, 8'h85}); rq.push_back({1'b1, 8'h95});
        @(posedge clk); #1;
        drive(0, 1'b1, 1'b0, 8'h20, 8'h00);
        drive(1, 1'b1, 1'b0, 8'h30, 8'h00);
        n = 0; t = 0; last_t = 0;
        for (int i = 0; i < 40 && n < 4; i++) begin
            @(negedge clk);
            t++;
            if (gnt0 || gnt1) begin
                if (n > 0) chk("contend_spacing", t - last_t, 3);
                last_t = t;
                n++;
            end
        end
        chk("contend_count", n, 4);
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b0, 8'h00, 8'h00);
        drive(1, 1'b0, 1'b0, 8'h00, 8'h00);
        repeat (3) @(negedge clk);

        // Port 1 back-to-back reads of 0x00..0x03 with req held
        for (int i = 0; i < 4; i++) begin
            gq.push_back(1);
            rq.push_back({1'b1, 8'(i) ^ 8'hA5});
        end
        @(posedge clk); #1;
        drive(1, 1'b1, 1'b0, 8'h00, 8'h00);
        n = 0; t = 0; last_t = 0; busy_lo = 0;
        for (int i = 0; i < 40 && n < 4; i++) begin
            @(negedge clk);
            t++;
            if (n > 0 && !busy) busy_lo++;
            if (gnt1) begin
                if (n > 0) chk("b2b_spacing", t - last_t, 3);
                last_t = t;
                n++;
                if (n < 4) addr1 = 8'(n);
                else req1 = 1'b0;
            end
        end
        chk("b2b_count", n, 4);
        chk("b2b_busy_low", busy_lo, 3);
        repeat (3) @(negedge clk);

        // Port 1 write to the top address, then read back
        access(1, 1'b1, 8'hFF, 8'h55, 8'h00);
        access(1, 1'b0, 8'hFF, 8'h00, 8'h55);

        // Port 1 request arriving during port-0 ISSUE waits for the next IDLE
        gq.push_back(0); gq.push_back(1);
        rq.push_back({1'b0, 8'h3C}); rq.push_back({1'b1, 8'hB4});
        @(posedge clk); #1;
        drive(0, 1'b1, 1'b0, 8'h10, 8'h00);
        n = 0;
        for (int i = 0; i < 20 && !gnt0; i++) @(negedge clk);
        chk("late_gnt0_seen", int'(gnt0), 1);
        drive(1, 1'b1, 1'b0, 8'h11, 8'h00);
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b0, 8'h00, 8'h00);
        t = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (gnt1) begin t = i; break; end
        end
        chk("late_gnt1_gap", t, 3);
        @(posedge clk); #1;
        drive(1, 1'b0, 1'b0, 8'h00, 8'h00);
        repeat (4) @(negedge clk);

        chk("gnt_queue_empty", gq.size(), 0);
        chk("rv_queue_empty", rq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
